// File: rtl/frame_reader_pkg.sv
// Shared state type, Wishbone cycle-type encodings and address helper for the
// burst framebuffer reader.
package frame_reader_pkg;

   typedef enum logic [1:0] {IDLE, BURST, GAP} fr_state_t;

   localparam logic [2:0] CTI_INCR   = 3'b010;
   localparam logic [2:0] CTI_EOB    = 3'b111;
   localparam logic [1:0] BTE_LINEAR = 2'b00;

   localparam int WORD_ADDR_W = 64;

   // Byte address of pixel idx; callers truncate to their bus width.
   function automatic logic [WORD_ADDR_W-1:0] word_addr(input logic [WORD_ADDR_W-1:0] base,
                                                        input logic [WORD_ADDR_W-1:0] idx);
      return base + (idx << 2);
   endfunction

endpackage

// File: rtl/fr_addr_gen.sv
// Pixel index tracker: advances per good beat, wraps at frame end, rewinds a
// failed burst to its first pixel and flags the write of the last pixel.
module fr_addr_gen #(
   parameter int NPIX  = 800 * 480,
   parameter int IDX_W = $clog2(NPIX)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             burst_start,
   input  logic             restart,
   input  logic             beat_ok,
   input  logic             beat_err,
   output logic [IDX_W-1:0] idx,
   output logic             frame_done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

   logic [IDX_W-1:0] burst_base;

   // NOTE: reset is synchronous, so it is simply the first branch of the clocked block.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx        <= '0;
         burst_base <= '0;
         frame_done <= 1'b0;
      end else begin
         // Lines up with fifo_write, which also lags the acked beat by one cycle.
         frame_done <= beat_ok && (idx == LAST_IDX);
         if (burst_start) begin
            if (restart) begin
               idx        <= '0;
               burst_base <= '0;
            end else begin
               burst_base <= idx;
            end
         end else if (beat_err) begin
            idx <= burst_base;
         end else if (beat_ok) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
         end
      end
   end

endmodule

// File: rtl/wshb_frame_reader.sv
// Wishbone B4 incrementing-burst master streaming a raster framebuffer into the
// write side of the display FIFO.
module wshb_frame_reader
   import frame_reader_pkg::*;
#(
   parameter int                HDISP     = 800,
   parameter int                VDISP     = 480,
   parameter int                BURST_LEN = 16,
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              frame_start,
   output logic [ADDR_W-1:0] wb_adr,
   output logic              wb_cyc,
   output logic              wb_stb,
   output logic              wb_we,
   output logic [3:0]        wb_sel,
   output logic [2:0]        wb_cti,
   output logic [1:0]        wb_bte,
   input  logic [31:0]       wb_dat_i,
   input  logic              wb_ack,
   input  logic              wb_err,
   input  logic              fifo_walmost_full,
   output logic [31:0]       fifo_wdata,
   output logic              fifo_write,
   output logic              frame_done,
   output logic              err_sticky
);

   localparam int NPIX   = HDISP * VDISP;
   localparam int IDX_W  = $clog2(NPIX);
   localparam int BEAT_W = $clog2(BURST_LEN);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

   fr_state_t         state, state_nx;
   logic [BEAT_W-1:0] beat, beat_nx;
   logic              restart_pending, restart_nx;
   logic              burst_start;
   logic [IDX_W-1:0]  idx;
   logic              beat_ok, beat_err;

   // Error beats are never written, even when the slave also raises ack.
   assign beat_ok  = (state == BURST) && wb_ack && !wb_err;
   assign beat_err = (state == BURST) && wb_err;

   fr_addr_gen #(.NPIX(NPIX), .IDX_W(IDX_W)) u_addr_gen (
      .clk         (clk),
      .rst_n       (rst_n),
      .burst_start (burst_start),
      .restart     (restart_pending),
      .beat_ok     (beat_ok),
      .beat_err    (beat_err),
      .idx         (idx),
      .frame_done  (frame_done)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         beat            <= '0;
         restart_pending <= 1'b0;
         fifo_write      <= 1'b0;
         fifo_wdata      <= '0;
         err_sticky      <= 1'b0;
      end else begin
         state           <= state_nx;
         beat            <= beat_nx;
         restart_pending <= restart_nx;
         fifo_write      <= beat_ok;
         if (beat_ok)  fifo_wdata <= wb_dat_i;
         if (beat_err) err_sticky <= 1'b1;
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nx    = state;
      beat_nx     = beat;
      burst_start = 1'b0;
      case (state)
         IDLE: begin
            if (enable && !fifo_walmost_full) begin
               state_nx    = BURST;
               burst_start = 1'b1;
            end
         end
         BURST: begin
            if (wb_err) begin
               state_nx = GAP;
               beat_nx  = '0;
            end else if (wb_ack) begin
               if (beat == LAST_BEAT) begin
                  state_nx = GAP;
                  beat_nx  = '0;
               end else begin
                  beat_nx = beat + 1'b1;
               end
            end
         end
         GAP:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase

      // A pulse coinciding with a burst start is kept for the following burst.
      restart_nx = burst_start ? 1'b0 : restart_pending;
      if (frame_start) restart_nx = 1'b1;
   end

   assign wb_cyc = (state == BURST);
   assign wb_stb = (state == BURST);
   assign wb_cti = (state != BURST) ? 3'b000 : (beat == LAST_BEAT) ? CTI_EOB : CTI_INCR;
   assign wb_adr = ADDR_W'(word_addr(WORD_ADDR_W'(BASE_ADDR), WORD_ADDR_W'(idx)));
   assign wb_we  = 1'b0;
   assign wb_sel = 4'b1111;
   assign wb_bte = BTE_LINEAR;

endmodule

// File: tb/tb_wshb_frame_reader.sv
// Directed bench for wshb_frame_reader: 32x8 frame, 16-beat bursts, reactive
// slave with programmable wait states and a one-shot bus error.
module tb_wshb_frame_reader;

   localparam int HDISP = 32, VDISP = 8, BURST_LEN = 16, ADDR_W = 32;
   localparam logic [31:0] BASE_ADDR = 32'h0;

   logic        clk = 1'b0;
   logic        rst_n, enable, frame_start, fifo_walmost_full;
   logic [31:0] wb_adr, wb_dat_i, fifo_wdata;
   logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
   logic [3:0]  wb_sel;
   logic [2:0]  wb_cti;
   logic [1:0]  wb_bte;
   logic        fifo_write, frame_done, err_sticky;

   int checks = 0, failures = 0;

   // Slave configuration, written only by the stimulus block.
   logic [31:0] stall_adr = 32'hFFFF_FFFF;
   int          stall_n = 0;
   logic [31:0] err_adr = 32'hFFFF_FFFF;
   int          err_budget = 0;
   // Slave state.
   int          hold_cnt = 0;
   int          err_count = 0;

   // Monitor records.
   int          cyc_n = 0, low_run = 0, stall_obs = 0;
   logic        cyc_prev = 1'b0;
   logic [31:0] wr_q[$], ack_adr_q[$], burst_q[$];
   logic [2:0]  ack_cti_q[$];
   int          wr_cyc_q[$], ack_cyc_q[$], fd_pos_q[$], gap_q[$];

   always #5 clk = ~clk;

   wshb_frame_reader #(
      .HDISP(HDISP), .VDISP(VDISP), .BURST_LEN(BURST_LEN), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .frame_start(frame_start),
      .wb_adr(wb_adr), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
      .wb_cti(wb_cti), .wb_bte(wb_bte), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .wb_err(wb_err),
      .fifo_walmost_full(fifo_walmost_full), .fifo_wdata(fifo_wdata), .fifo_write(fifo_write),
      .frame_done(frame_done), .err_sticky(err_sticky)
   );

   function automatic logic [31:0] pix(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   assign wb_dat_i = pix(wb_adr);
   assign wb_ack   = wb_stb && ((wb_adr != stall_adr) || (hold_cnt >= stall_n));
   assign wb_err   = wb_stb && (wb_adr == err_adr) && (err_count < err_budget);

   always @(posedge clk) begin
      hold_cnt <= (wb_stb && !wb_ack && !wb_err) ? hold_cnt + 1 : 0;
      if (wb_err) err_count <= err_count + 1;
   end

   always @(negedge clk) begin
      cyc_n <= cyc_n + 1;
      if (wb_stb && wb_ack && !wb_err) begin
         ack_adr_q.push_back(wb_adr);
         ack_cti_q.push_back(wb_cti);
         ack_cyc_q.push_back(cyc_n);
      end
      if (wb_stb && !wb_ack && (wb_adr == stall_adr)) stall_obs <= stall_obs + 1;
      if (fifo_write) begin
         wr_q.push_back(fifo_wdata);
         wr_cyc_q.push_back(cyc_n);
      end
      if (frame_done) fd_pos_q.push_back(wr_q.size());
      if (wb_cyc && !cyc_prev) begin
         burst_q.push_back(wb_adr);
         gap_q.push_back(low_run);
      end
      low_run  <= wb_cyc ? 0 : low_run + 1;
      cyc_prev <= wb_cyc;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   function automatic int count_of(input int kind);
      case (kind)
         0:       return burst_q.size();
         1:       return wr_q.size();
         2:       return ack_adr_q.size();
         default: return fd_pos_q.size();
      endcase
   endfunction

   // Bounded wait for a monitor count (0 bursts, 1 writes, 2 acks, 3 frame_done).
   task automatic wait_for(input int kind, input int n, input string tag);
      int budget = 1000;
      while (count_of(kind) < n && budget > 0) begin
         sample();
         budget--;
      end
      check(tag, 32'(count_of(kind) >= n), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cyc"}, 32'(wb_cyc), 0);
      check({tag, "_stb"}, 32'(wb_stb), 0);
      check({tag, "_cti"}, 32'(wb_cti), 0);
      check({tag, "_fwr"}, 32'(fifo_write), 0);
      check({tag, "_fdat"}, fifo_wdata, 0);
      check({tag, "_fdone"}, 32'(frame_done), 0);
      check({tag, "_err"}, 32'(err_sticky), 0);
      check({tag, "_adr"}, wb_adr, BASE_ADDR);
   endtask

   initial begin
      int bad;
      rst_n = 1'b0; enable = 1'b0; frame_start = 1'b0; fifo_walmost_full = 1'b0;

      // Reset state and constant outputs.
      repeat (4) sample();
      check_reset_outputs("rst");
      check("we", 32'(wb_we), 0);
      check("sel", 32'(wb_sel), 32'hF);
      check("bte", 32'(wb_bte), 0);

      // 1: two bursts back to back, stop with enable dropped mid-burst.
      rst_n = 1'b1; enable = 1'b1;
      wait_for(0, 2, "s1_two_bursts");
      enable = 1'b0;
      check("s1_start0", burst_q[0], 32'h0);
      check("s1_start1", burst_q[1], 32'h40);
      check("s1_gap", 32'(gap_q[1]), 2);
      wait_for(1, 32, "s1_writes");
      repeat (10) sample();
      check("s1_no_more_bursts", 32'(burst_q.size()), 2);
      check("s1_cyc_idle", 32'(wb_cyc), 0);
      check("s1_wr_count", 32'(wr_q.size()), 32);
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         if (ack_adr_q[i] !== 32'(4 * i)) bad++;
         if (wr_q[i] !== pix(32'(4 * i))) bad++;
         if (wr_cyc_q[i] - ack_cyc_q[i] != 1) bad++;
      end
      check("s1_adr_data_lat", 32'(bad), 0);
      bad = 0;
      for (int i = 0; i < 16; i++)
         if (ack_cti_q[i] !== ((i == 15) ? 3'b111 : 3'b010)) bad++;
      check("s1_cti", 32'(bad), 0);

      // 2: run through the frame end and into the wrapped burst.
      enable = 1'b1;
      wait_for(3, 1, "s2_frame_done");
      wait_for(0, 17, "s2_wrap_burst");
      enable = 1'b0;
      check("s2_wrap_adr", burst_q[16], BASE_ADDR);
      check("s2_fd_pos", 32'(fd_pos_q[0]), 256);
      check("s2_last_pix", wr_q[255], pix(32'h3FC));
      wait_for(1, 272, "s2_writes");
      repeat (10) sample();
      check("s2_fd_once", 32'(fd_pos_q.size()), 1);
      check("s2_wr_count", 32'(wr_q.size()), 272);
      bad = 0;
      for (int i = 32; i < 272; i++) begin
         if (ack_adr_q[i] !== 32'(4 * (i % 256))) bad++;
         if (wr_q[i] !== pix(32'(4 * (i % 256)))) bad++;
      end
      check("s2_stream", 32'(bad), 0);

      // 3: almost-full raised mid-burst holds off the next burst.
      enable = 1'b1;
      wait_for(0, 18, "s3_start");
      check("s3_adr", burst_q[17], 32'h40);
      wait_for(2, 280, "s3_mid");
      fifo_walmost_full = 1'b1;
      wait_for(1, 288, "s3_writes");
      repeat (20) sample();
      check("s3_held_bursts", 32'(burst_q.size()), 18);
      check("s3_held_cyc", 32'(wb_cyc), 0);
      check("s3_held_writes", 32'(wr_q.size()), 288);

      // 4: three wait states on beat 5 of the burst at 0x80.
      stall_adr = 32'h94; stall_n = 3;
      fifo_walmost_full = 1'b0;
      wait_for(0, 19, "s4_start");
      enable = 1'b0;
      check("s4_adr", burst_q[18], 32'h80);
      wait_for(1, 304, "s4_writes");
      repeat (5) sample();
      stall_adr = 32'hFFFF_FFFF;
      check("s4_wait_states", 32'(stall_obs), 3);
      check("s4_wr_count", 32'(wr_q.size()), 304);
      check("s4_beat5_adr", ack_adr_q[293], 32'h94);
      check("s4_beat5_lat", 32'(wr_cyc_q[293] - ack_cyc_q[293]), 1);
      bad = 0;
      for (int i = 272; i < 304; i++) begin
         if (ack_adr_q[i] !== 32'h40 + 32'(4 * (i - 272))) bad++;
         if (wr_q[i] !== pix(32'h40 + 32'(4 * (i - 272)))) bad++;
         if (wr_cyc_q[i] - ack_cyc_q[i] != 1) bad++;
      end
      check("s4_stream", 32'(bad), 0);

      // 5: bus error (with ack also high) on beat 7 of the burst at 0x100.
      check("s5_err_before", 32'(err_sticky), 0);
      err_adr = 32'h11C; err_budget = 1;
      enable = 1'b1;
      wait_for(0, 22, "s5_refetch");
      enable = 1'b0;
      wait_for(1, 343, "s5_writes");
      repeat (10) sample();
      check("s5_err_sticky", 32'(err_sticky), 1);
      check("s5_start_c0", burst_q[19], 32'hC0);
      check("s5_start_100", burst_q[20], 32'h100);
      check("s5_refetch_adr", burst_q[21], 32'h100);
      check("s5_refetch_gap", 32'(gap_q[21]), 2);
      check("s5_wr_count", 32'(wr_q.size()), 343);
      check("s5_last_cti", 32'(ack_cti_q[342]), 32'h7);
      bad = 0;
      for (int k = 0; k < 16; k++) if (wr_q[304 + k] !== pix(32'hC0 + 32'(4 * k))) bad++;
      for (int k = 0; k < 7; k++)  if (wr_q[320 + k] !== pix(32'h100 + 32'(4 * k))) bad++;
      for (int k = 0; k < 16; k++) if (wr_q[327 + k] !== pix(32'h100 + 32'(4 * k))) bad++;
      check("s5_data", 32'(bad), 0);

      // 6: frame_start during the burst at idx 160, then reset mid-burst.
      enable = 1'b1;
      wait_for(0, 28, "s6_reach_160");
      check("s6_adr160", burst_q[27], 32'h280);
      repeat (3) sample();
      frame_start = 1'b1; sample();
      frame_start = 1'b0; sample();
      frame_start = 1'b1; sample();
      frame_start = 1'b0;
      wait_for(0, 29, "s6_restart");
      check("s6_restart_adr", burst_q[28], BASE_ADDR);
      check("s6_inflight_end", ack_adr_q[438], 32'h2BC);
      check("s6_inflight_wr", 32'(wr_q.size()), 439);
      wait_for(2, 444, "s6_mid_burst");
      rst_n = 1'b0;
      sample();
      check_reset_outputs("s6_rst");
      repeat (10) sample();
      check("s6_no_writes", 32'(wr_q.size()), 443);
      check("s6_cyc_low", 32'(wb_cyc), 0);
      bad = 0;
      for (int k = 0; k < 4; k++) if (wr_q[439 + k] !== pix(32'(4 * k))) bad++;
      check("s6_restart_data", 32'(bad), 0);
      check("s6_fd_once", 32'(fd_pos_q.size()), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
